// File: rtl/flgwei_gb_arb.sv
// flgwei_gb_arb: round-robin arbiter for the shared weight-flag GB read port.
// One PEB is served at a time for a fixed burst of BURST_LEN beats. The GB is
// told which PEB is served, and its valid is routed to that PEB only. The data
// bus goes to every PEB.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   next_block   synchronous pulse: abort the burst, return to IDLE, pointer to 0
//   PEB_Rdy      per-PEB ready/request (level)
//   PEB_Val      per-PEB valid, one-hot or zero
//   PEB_Data     GB data broadcast to all PEBs
//   GB_Rdy       ready to the GB read channel
//   GB_Val       GB data valid
//   GB_Data      GB flag-weight data
//   GB_Idx       granted PEB index (0 while idle)
//   GB_Idx_Val   grant active
//   Busy         high while in XFER
//
// Configuration macro: FLGWEI_ARB_FIXPRIO_EN. When it is defined, the arbiter
// uses fixed priority (lowest index wins) and the pointer stays at 0.

`ifndef BUSWIDTH_FLGWEI
`define BUSWIDTH_FLGWEI 32
`endif

module flgwei_gb_arb #(
    parameter int unsigned NUM_PEB    = 4,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned DATA_WIDTH = `BUSWIDTH_FLGWEI,
    parameter int unsigned IDX_W      = $clog2(NUM_PEB)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  next_block,
    input  logic [NUM_PEB-1:0]    PEB_Rdy,
    output logic [NUM_PEB-1:0]    PEB_Val,
    output logic [DATA_WIDTH-1:0] PEB_Data,
    output logic                  GB_Rdy,
    input  logic                  GB_Val,
    input  logic [DATA_WIDTH-1:0] GB_Data,
    output logic [IDX_W-1:0]      GB_Idx,
    output logic                  GB_Idx_Val,
    output logic                  Busy
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             found;
    logic [IDX_W-1:0] pick;
    logic             beat;
    logic [IDX_W-1:0] grant_nxt;

    // The data bus has no registered stage.
    assign PEB_Data = GB_Data;

    // First requester at or above ptr, wrapping at NUM_PEB.
    always_comb begin
        int unsigned      idx;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_PEB; i++) begin
            idx  = (32'(ptr_q) + i) % NUM_PEB;
            cand = IDX_W'(idx);
            if (!found && PEB_Rdy[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Round-robin pointer after the burst completes.
    assign grant_nxt = (grant_q == IDX_W'(NUM_PEB - 1)) ? '0 : grant_q + IDX_W'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        GB_Rdy     = 1'b0;
        PEB_Val    = '0;
        GB_Idx     = '0;
        GB_Idx_Val = 1'b0;
        Busy       = 1'b0;
        beat       = 1'b0;

        if (state_q == XFER) begin
            GB_Idx     = grant_q;
            GB_Idx_Val = 1'b1;
            Busy       = 1'b1;
            // next_block masks the handshake so that no beat is consumed.
            if (!next_block) begin
                GB_Rdy           = PEB_Rdy[grant_q];
                PEB_Val[grant_q] = GB_Val;
            end
        end
        beat = GB_Val & GB_Rdy;

        if (next_block) begin
            state_d = IDLE;
            ptr_d   = '0;
            grant_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_d = pick;
                        cnt_d   = '0;
                        state_d = XFER;
                    end
                end
                XFER: begin
                    if (beat) begin
                        if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                            state_d = IDLE;
                            cnt_d   = '0;
`ifdef FLGWEI_ARB_FIXPRIO_EN
                            ptr_d   = '0;
`else
                            ptr_d   = grant_nxt;
`endif
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
